axi4_lite_regfile: RTL and testbench
====================================

Name: axi4_lite_regfile

Overview:
- Parametrised AXI4-Lite slave register file; next generation of the fixed-width register wrapper.
- Generalises data width, register count and per-register access mode.
- Adds byte strobes, read-only (hardware-sourced) registers, a per-register write strobe, and SLVERR decode.
- Sits between an AXI VIP/interconnect master and fabric control/status logic.

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64 only
ADDR_WIDTH, 12, AXI byte-address width
REGISTERS, 16, number of implemented registers; 1..2**(ADDR_WIDTH-log2(DATA_WIDTH/8))
RO_MASK, 0, REGISTERS-bit vector; bit i=1 makes register i read-only (value from hw_in)
RESET_VALUE, 0, DATA_WIDTH reset value of every RW register

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
hw_out  out  REGISTERS*DATA_WIDTH  flattened register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
hw_in  in  REGISTERS*DATA_WIDTH  values for RO registers (ignored for RW)
wr_pulse  out  REGISTERS  one-cycle pulse on each successful write commit

Behaviour:
- Clock aclk; reset areset is synchronous and active-high.
- Reset: all RW registers=RESET_VALUE; bvalid=rvalid=0; awready=wready=arready=1; bresp=rresp=0; rdata=0; wr_pulse=0.
- Index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low byte-offset bits ignored.
- Write channel, states W_IDLE, W_RESP:
  - In W_IDLE, AW and W are accepted independently in any order or the same cycle; each is latched, and its ready drops after its handshake.
  - The cycle both are latched: commit (registered), then bvalid=1 next cycle and enter W_RESP.
  - W_RESP: hold bvalid/bresp until bready; on handshake, return to W_IDLE with awready=wready=1 the following cycle.
  - Write latency: AW+W both handshaken in cycle N -> bvalid in N+1.
- Commit:
  - index<REGISTERS and RO_MASK[index]=0: each byte k with wstrb[k]=1 is updated; bresp=OKAY(00); wr_pulse[index]=1 for exactly one cycle (the commit cycle+1, aligned with bvalid rise).
  - index>=REGISTERS or RO register: no state change, no pulse, bresp=SLVERR(10).
  - wstrb=0 to a valid RW register: OKAY, no change, wr_pulse still asserted.
- Read channel, states R_IDLE, R_DATA:
  - AR handshake in cycle N -> rvalid=1, rdata valid in N+1, arready=0.
  - Hold rvalid/rdata/rresp stable until rready; then arready=1 next cycle.
  - rdata = RW register, or hw_in slice for RO, sampled at the AR handshake cycle.
  - Out-of-range read: rdata=0, rresp=SLVERR.
- Simultaneous read and commit to the same register in the same cycle: read returns the pre-write value; next read returns the new value.
- Read and write channels are fully independent; both may be in flight concurrently.
- hw_out for an RO index drives the hw_in slice; for an RW index it drives the register.
- areset asserted mid-transaction: all state returns to reset values the next cycle; pending responses are dropped.

Test Plan:
- Sequential write then read of every register i with data=i at addr=4*i (DATA_WIDTH=32, REGISTERS=16) -> each bresp=OKAY, rdata=i, wr_pulse[i] single-cycle.
- Write 0xAABBCCDD then 0x11223344 with wstrb=0101 to reg 2 -> read returns 0xAA22CC44.
- W presented 3 cycles before AW, with bready held low 5 cycles -> single commit, bvalid held stable 5 cycles, awready/wready stay low until B handshake.
- RO_MASK bit 3 set, hw_in[3]=0xDEADBEEF; write reg 3 -> SLVERR, no wr_pulse; read reg 3 -> 0xDEADBEEF, OKAY.
- Write and read addr=4*REGISTERS -> bresp=SLVERR, rresp=SLVERR, rdata=0, no register change.
- Same-cycle AR and write commit on reg 5 (old 0x5, new 0x55) -> rdata=0x5; following read returns 0x55. Then assert areset during pending bvalid -> bvalid=0, reg 5 reads RESET_VALUE.

Source files
------------

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file.
//
// Implements REGISTERS data-width registers behind an AXI4-Lite slave port.
// Registers flagged in RO_MASK are read-only and reflect the matching hw_in
// slice. Writes honour byte strobes. Writes to read-only or unimplemented
// registers, and reads of unimplemented registers, return SLVERR.
//
// Ports:
//   aclk, areset     clock, synchronous active-high reset
//   s_axi_aw*        write address channel
//   s_axi_w*         write data channel (wdata, wstrb)
//   s_axi_b*         write response channel
//   s_axi_ar*        read address channel
//   s_axi_r*         read data channel
//   hw_out           flattened register view (hw_in slice for read-only registers)
//   hw_in            values for read-only registers
//   wr_pulse         one-cycle pulse per register on each successful write
module axi4_lite_regfile #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 12,
  parameter int unsigned            REGISTERS   = 16,
  parameter logic [REGISTERS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [ADDR_WIDTH-1:0]           s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [DATA_WIDTH-1:0]           s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]         s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]           s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [DATA_WIDTH-1:0]           s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [REGISTERS*DATA_WIDTH-1:0] hw_out,
  input  logic [REGISTERS*DATA_WIDTH-1:0] hw_in,
  output logic [REGISTERS-1:0]            wr_pulse
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [IDX_WIDTH-1:0]    aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [REGISTERS-1:0]    wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0]   regs_q [REGISTERS];
  logic [DATA_WIDTH-1:0]   regs_d [REGISTERS];

  // Channel payload for the current cycle: latched copy if already taken, else the bus.
  logic [IDX_WIDTH-1:0]    aw_idx_cur, ar_idx;
  logic [DATA_WIDTH-1:0]   wdata_cur;
  logic [STRB_WIDTH-1:0]   wstrb_cur;
  logic                    aw_hs, w_hs;

  // Byte-offset address bits carry no information for a word-wide register file.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

  assign s_axi_awready = (w_state_q == WIdle) && !aw_done_q;
  assign s_axi_wready  = (w_state_q == WIdle) && !w_done_q;
  assign s_axi_arready = (r_state_q == RIdle);
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign wr_pulse      = wr_pulse_q;

  assign aw_hs      = s_axi_awvalid && s_axi_awready;
  assign w_hs       = s_axi_wvalid && s_axi_wready;
  assign aw_idx_cur = aw_done_q ? aw_idx_q : s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign wdata_cur  = w_done_q ? wdata_q : s_axi_wdata;
  assign wstrb_cur  = w_done_q ? wstrb_q : s_axi_wstrb;
  assign ar_idx     = s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];

  for (genvar g = 0; g < REGISTERS; g++) begin : g_hw_out
    assign hw_out[g*DATA_WIDTH +: DATA_WIDTH] =
        RO_MASK[g] ? hw_in[g*DATA_WIDTH +: DATA_WIDTH] : regs_q[g];
  end

  // Write channel: AW and W are taken independently, commit when both are held.
  always_comb begin
    w_state_d  = w_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          aw_idx_d  = s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          w_state_d = WResp;
          bvalid_d  = 1'b1;
          bresp_d   = RespSlverr;
          for (int i = 0; i < REGISTERS; i++) begin
            if (aw_idx_cur == IDX_WIDTH'(i) && !RO_MASK[i]) begin
              bresp_d       = RespOkay;
              wr_pulse_d[i] = 1'b1;
              for (int k = 0; k < STRB_WIDTH; k++) begin
                if (wstrb_cur[k]) regs_d[i][k*8 +: 8] = wdata_cur[k*8 +: 8];
              end
            end
          end
        end
      end
      WResp: begin
        if (s_axi_bready) begin
          w_state_d = WIdle;
          bvalid_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
    endcase
  end

  // Read channel: data is sampled at the AR handshake, so a same-cycle commit
  // to the same register is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      RIdle: begin
        if (s_axi_arvalid) begin
          r_state_d = RData;
          rvalid_d  = 1'b1;
          rresp_d   = RespSlverr;
          rdata_d   = '0;
          for (int i = 0; i < REGISTERS; i++) begin
            if (ar_idx == IDX_WIDTH'(i)) begin
              rresp_d = RespOkay;
              rdata_d = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
          end
        end
      end
      RData: begin
        if (s_axi_rready) begin
          r_state_d = RIdle;
          rvalid_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q  <= WIdle;
      r_state_q  <= RIdle;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      rvalid_q   <= 1'b0;
      rresp_q    <= RespOkay;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < REGISTERS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Bench for axi4_lite_regfile: directed transactions, a word-array model of the
// register file, and a per-cycle compare of hw_out / wr_pulse against it.
module tb_axi4_lite_regfile;

  localparam int DW   = 32;
  localparam int AW   = 12;
  localparam int NREG = 16;
  localparam logic [NREG-1:0] RO      = 16'h0008;
  localparam logic [DW-1:0]   RST_VAL = 32'hC0DE_0000;

  logic              aclk = 1'b0;
  logic              areset;
  logic [AW-1:0]     awaddr, araddr;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DW-1:0]     wdata, rdata;
  logic [DW/8-1:0]   wstrb;
  logic [1:0]        bresp, rresp;
  logic [NREG*DW-1:0] hw_out, hw_in;
  logic [NREG-1:0]   wr_pulse;

  axi4_lite_regfile #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .REGISTERS  (NREG),
    .RO_MASK    (RO),
    .RESET_VALUE(RST_VAL)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axi_awaddr (awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .hw_out       (hw_out),
    .hw_in        (hw_in),
    .wr_pulse     (wr_pulse)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] model [NREG];
  int pulse_idx = -1;
  int pulse_cyc = -1;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model[i] = RST_VAL;
    pulse_cyc = -1;
    pulse_idx = -1;
  endtask

  // What a register reads as: hardware value for read-only, stored word otherwise.
  function automatic logic [DW-1:0] reg_view(input int idx);
    return RO[idx] ? hw_in[idx*DW +: DW] : model[idx];
  endfunction

  function automatic logic [NREG*DW-1:0] exp_hw_out();
    logic [NREG*DW-1:0] v;
    for (int i = 0; i < NREG; i++) v[i*DW +: DW] = reg_view(i);
    return v;
  endfunction

  function automatic logic [NREG-1:0] exp_pulse();
    logic [NREG-1:0] v = '0;
    if (pulse_idx >= 0 && cyc == pulse_cyc) v[pulse_idx] = 1'b1;
    return v;
  endfunction

  always @(negedge aclk) begin
    if (chk_en) begin
      check("hw_out", hw_out, exp_hw_out());
      check("wr_pulse", wr_pulse, exp_pulse());
    end
  end

  // W is presented w_lead cycles before AW; bready held low bdelay cycles
  // (bdelay < 0 leaves the response pending).
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [DW/8-1:0] strb, input int w_lead, input int bdelay);
    int c = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, okay;
    int idx = int'(addr[AW-1:2]);
    okay = (idx < NREG) ? !RO[idx] : 1'b0;
    wvalid = 1'b1; wdata = data; wstrb = strb; awaddr = addr;
    awvalid = (w_lead == 0);
    while (!(aw_done && w_done)) begin
      @(negedge aclk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      check("bvalid_before_commit", bvalid, 1'b0);
      if (w_done && !aw_done) check("wready_low_after_w", wready, 1'b0);
      @(posedge aclk); #1;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs) begin w_done = 1; wvalid = 1'b0; end
      c++;
      if (!aw_done && !awvalid && c >= w_lead) awvalid = 1'b1;
      if (c > 50) begin
        n_cmp++; n_err++;
        $display("FAIL write_handshake_timeout: addr %0h not accepted in 50 cycles", addr);
        awvalid = 1'b0; wvalid = 1'b0;
        return;
      end
    end
    if (okay) begin
      for (int k = 0; k < DW/8; k++) if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
      pulse_idx = idx;
      pulse_cyc = cyc;
    end
    for (int i = 0; ; i++) begin
      bready = (bdelay >= 0) && (i >= bdelay);
      @(negedge aclk);
      check("bvalid", bvalid, 1'b1);
      check("bresp", bresp, okay ? 2'b00 : 2'b10);
      check("awready_during_b", awready, 1'b0);
      check("wready_during_b", wready, 1'b0);
      @(posedge aclk); #1;
      if (bdelay < 0) return;
      if (i >= bdelay) break;
    end
    bready = 1'b0;
    @(negedge aclk);
    check("bvalid_after_b", bvalid, 1'b0);
    check("awready_after_b", awready, 1'b1);
    check("wready_after_b", wready, 1'b1);
    @(posedge aclk); #1;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int rdelay, output logic [DW-1:0] got);
    bit hs;
    int c = 0;
    int idx = int'(addr[AW-1:2]);
    logic [DW-1:0] exp_d;
    logic [1:0] exp_r;
    got = '0;
    araddr = addr; arvalid = 1'b1;
    do begin
      @(negedge aclk);
      hs = arready;
      // Expected data is what the register holds in the handshake cycle.
      exp_d = (idx < NREG) ? reg_view(idx) : '0;
      exp_r = (idx < NREG) ? 2'b00 : 2'b10;
      check("rvalid_before_ar", rvalid, 1'b0);
      @(posedge aclk); #1;
      c++;
      if (c > 50) begin
        n_cmp++; n_err++;
        $display("FAIL read_handshake_timeout: addr %0h not accepted in 50 cycles", addr);
        arvalid = 1'b0;
        return;
      end
    end while (!hs);
    arvalid = 1'b0;
    for (int i = 0; ; i++) begin
      rready = (i >= rdelay);
      @(negedge aclk);
      check("rvalid", rvalid, 1'b1);
      check("rdata", rdata, exp_d);
      check("rresp", rresp, exp_r);
      check("arready_during_r", arready, 1'b0);
      got = rdata;
      @(posedge aclk); #1;
      if (i >= rdelay) break;
    end
    rready = 1'b0;
    @(negedge aclk);
    check("rvalid_after_r", rvalid, 1'b0);
    check("arready_after_r", arready, 1'b1);
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    model_reset();
    @(negedge aclk);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_awready", awready, 1'b1);
    check("rst_wready", wready, 1'b1);
    check("rst_arready", arready, 1'b1);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_rdata", rdata, '0);
    @(posedge aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got, got2;
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NREG; i++) hw_in[i*DW +: DW] = 32'hF00D_0000 | i;
    hw_in[3*DW +: DW] = 32'hDEAD_BEEF;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    @(negedge aclk);
    check("reset_rdata", rdata, '0);
    check("reset_awready", awready, 1'b1);
    check("reset_bvalid", bvalid, 1'b0);
    check("reset_hw_out_reg0", hw_out[DW-1:0], RST_VAL);
    @(posedge aclk); #1;

    // Every register: write i, read back.
    for (int i = 0; i < NREG; i++) begin
      do_write(AW'(4 * i), DW'(i), 4'hF, 0, 0);
      do_read(AW'(4 * i), 0, got);
      if (i != 3) check("seq_readback_literal", got, DW'(i));
    end

    // Byte strobes.
    do_write(12'h008, 32'hAABB_CCDD, 4'hF, 0, 0);
    do_write(12'h008, 32'h1122_3344, 4'b0101, 0, 0);
    do_read(12'h008, 0, got);
    check("strobe_merge_literal", got, 32'hAA22_CC44);

    // W ahead of AW, slow bready.
    do_write(12'h01C, 32'h0000_0077, 4'hF, 3, 5);
    do_read(12'h01C, 2, got);
    check("w_first_literal", got, 32'h0000_0077);

    // Read-only register.
    do_write(12'h00C, 32'h1234_5678, 4'hF, 0, 0);
    do_read(12'h00C, 0, got);
    check("ro_read_literal", got, 32'hDEAD_BEEF);

    // Empty strobe to a RW register: OKAY with pulse, contents unchanged.
    do_write(12'h010, 32'hFFFF_FFFF, 4'h0, 0, 0);
    do_read(12'h010, 0, got);
    check("zero_strb_literal", got, 32'h0000_0004);

    // Out of range and low byte-offset bits.
    do_write(12'h040, 32'hCAFE_F00D, 4'hF, 0, 1);
    do_read(12'h040, 1, got);
    check("oor_read_literal", got, 32'h0);
    do_write(12'h01B, 32'h1234_5678, 4'hF, 0, 0);
    do_read(12'h019, 0, got);
    check("byte_offset_literal", got, 32'h1234_5678);

    // Same-cycle AR and commit on reg 5.
    do_write(12'h014, 32'h0000_0005, 4'hF, 0, 0);
    fork
      do_write(12'h014, 32'h0000_0055, 4'hF, 0, 0);
      do_read(12'h014, 0, got);
    join
    check("same_cycle_old_literal", got, 32'h0000_0005);
    do_read(12'h014, 0, got2);
    check("same_cycle_new_literal", got2, 32'h0000_0055);

    // Reset while a write response is pending.
    do_write(12'h014, 32'h0000_0066, 4'hF, 0, -1);
    do_reset();
    do_read(12'h014, 0, got);
    check("after_reset_literal", got, RST_VAL);
    do_write(12'h004, 32'h0BAD_CAFE, 4'hF, 0, 0);
    do_read(12'h004, 0, got);
    check("post_reset_write_literal", got, 32'h0BAD_CAFE);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
